// File: rtl/mac_tap_sequencer_if.sv
// Sample intake, coefficient write port and MAC drive bundle for mac_tap_sequencer.
// The master side (producer/host) drives the inputs. The slave side is the sequencer.
interface mac_tap_sequencer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 16,
  parameter int TAP_IDX_W   = 3
);
  logic [DATA_WIDTH-1:0]  sample_in;
  logic                   sample_valid;
  logic                   sample_ready;
  logic                   coeff_wr_en;
  logic [TAP_IDX_W-1:0]   coeff_wr_addr;
  logic [COEFF_WIDTH-1:0] coeff_wr_data;
  logic                   coeff_wr_err;
  logic [DATA_WIDTH-1:0]  data_out;
  logic [COEFF_WIDTH-1:0] coeff_out;
  logic                   mac_enable;
  logic                   accum_clear;
  logic                   frame_done;
  logic                   busy;

  modport master (
    output sample_in, sample_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
    input  sample_ready, coeff_wr_err, data_out, coeff_out, mac_enable,
           accum_clear, frame_done, busy
  );

  modport slave (
    input  sample_in, sample_valid, coeff_wr_en, coeff_wr_addr, coeff_wr_data,
    output sample_ready, coeff_wr_err, data_out, coeff_out, mac_enable,
           accum_clear, frame_done, busy
  );
endinterface

// File: rtl/mac_tap_sequencer.sv
// FIR tap sequencer that feeds a two-stage MAC.
// Each accepted sample shifts into the delay line. The block then clears the MAC,
// streams NUM_TAPS (sample, coeff) pairs and sends two zero pairs to flush the MAC
// pipeline. frame_done flags the cycle in which the MAC accumulator is final.
// The registered outputs are computed from the next state, so each one lines up
// with the state it belongs to.
module mac_tap_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 8,
  parameter int TAP_IDX_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_tap_sequencer_if.slave    bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  localparam logic [TAP_IDX_W-1:0] K_LAST = TAP_IDX_W'(NUM_TAPS - 1);
  localparam logic [TAP_IDX_W-1:0] K_ONE  = TAP_IDX_W'(1);

  state_t                                state, state_nxt;
  logic [TAP_IDX_W-1:0]                  k, k_nxt;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]   delay;
  logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0]  coeff;
  logic [DATA_WIDTH-1:0]                 data_sel;
  logic [COEFF_WIDTH-1:0]                coeff_sel;
  logic                                  accept, wr_ok;

  assign bus.sample_ready = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign accept           = bus.sample_valid && (state == IDLE);
  assign wr_ok            = bus.coeff_wr_en && (state == IDLE) &&
                            (32'(bus.coeff_wr_addr) < 32'(NUM_TAPS));

  // Next-state logic. k counts taps in RUN and reuses 0..1 to count DRAIN cycles.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    unique case (state)
      IDLE:  if (accept) state_nxt = CLEAR;
      CLEAR: begin state_nxt = RUN; k_nxt = '0; end
      RUN:   if (k == K_LAST) begin state_nxt = DRAIN; k_nxt = '0; end
             else k_nxt = k + K_ONE;
      DRAIN: if (k == K_ONE) begin state_nxt = DONE; k_nxt = '0; end
             else k_nxt = k + K_ONE;
      DONE:  state_nxt = IDLE;
      default: begin state_nxt = IDLE; k_nxt = '0; end
    endcase
  end

  // Tap select for the next cycle's pair. The compare loop keeps the index width clean.
  always_comb begin
    data_sel  = '0;
    coeff_sel = '0;
    for (int i = 0; i < NUM_TAPS; i++)
      if (k_nxt == TAP_IDX_W'(i)) begin
        data_sel  = delay[i];
        coeff_sel = coeff[i];
      end
  end

  // State and tap counter registers.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
    end

  // Delay line: the newest sample goes to entry 0 and older ones shift up.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      delay <= '0;
    else if (accept) delay <= {delay[NUM_TAPS-2:0], bus.sample_in};

  // Coefficient bank. Writes land only while idle, so RUN never sees a change mid-frame.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) coeff <= '0;
    else
      for (int i = 0; i < NUM_TAPS; i++)
        if (wr_ok && bus.coeff_wr_addr == TAP_IDX_W'(i)) coeff[i] <= bus.coeff_wr_data;

  // Registered MAC drive, frame_done and write-error pulses.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.mac_enable   <= 1'b0;
      bus.accum_clear  <= 1'b0;
      bus.data_out     <= '0;
      bus.coeff_out    <= '0;
      bus.frame_done   <= 1'b0;
      bus.coeff_wr_err <= 1'b0;
    end else begin
      bus.mac_enable   <= (state_nxt == RUN) || (state_nxt == DRAIN);
      bus.accum_clear  <= (state_nxt == CLEAR);
      bus.data_out     <= (state_nxt == RUN) ? data_sel  : '0;
      bus.coeff_out    <= (state_nxt == RUN) ? coeff_sel : '0;
      bus.frame_done   <= (state == DONE);
      bus.coeff_wr_err <= bus.coeff_wr_en && !wr_ok;
    end
endmodule

// File: tb/tb_mac_tap_sequencer.sv
// Directed bench for mac_tap_sequencer (NUM_TAPS=8, 4-bit tap index) with a small MAC model.
module tb_mac_tap_sequencer;
  localparam int DW = 32, CW = 16, NT = 8, IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0, errors = 0;

  mac_tap_sequencer_if #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .TAP_IDX_W(IW)) bus ();

  mac_tap_sequencer #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .NUM_TAPS(NT), .TAP_IDX_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // MAC model: input register stage, multiply stage, then accumulate.
  logic [DW-1:0]    m_d;
  logic [CW-1:0]    m_c;
  logic [DW+CW-1:0] m_mult;
  logic [63:0]      m_acc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_d <= '0; m_c <= '0; m_mult <= '0; m_acc <= '0;
    end else if (bus.accum_clear) m_acc <= '0;
    else if (bus.mac_enable) begin
      m_d    <= bus.data_out;
      m_c    <= bus.coeff_out;
      m_mult <= m_d * m_c;
      m_acc  <= m_acc + 64'(m_mult);
    end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.sample_in = '0; bus.sample_valid = 1'b0;
    bus.coeff_wr_en = 1'b0; bus.coeff_wr_addr = '0; bus.coeff_wr_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load_coeffs();
    for (int i = 0; i < NT; i++) begin
      bus.coeff_wr_en = 1'b1; bus.coeff_wr_addr = IW'(i); bus.coeff_wr_data = CW'(i + 1);
      tick();
    end
    bus.coeff_wr_en = 1'b0;
  endtask

  // Present a sample in an IDLE cycle. This returns at the CLEAR observation.
  task automatic send(input logic [DW-1:0] s);
    bus.sample_in = s; bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.sample_ready, bus.busy, bus.mac_enable, bus.accum_clear, bus.frame_done,
         bus.coeff_wr_err, bus.data_out, bus.coeff_out} !== {1'b1, 1'b0, 4'b0, 48'd0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b busy=%b en=%b clr=%b d=%0d c=%0d", bus.sample_ready,
               bus.busy, bus.mac_enable, bus.accum_clear, bus.data_out, bus.coeff_out);
    end
  endtask

  task automatic test_single_frame();
    do_reset(); load_coeffs(); send(5);
    checks++;
    if ({bus.accum_clear, bus.mac_enable, bus.busy} !== 3'b101) begin
      errors++; $display("FAIL clear_cycle clr=%b en=%b busy=%b want 1 0 1", bus.accum_clear, bus.mac_enable, bus.busy);
    end
    for (int k = 0; k < NT; k++) begin
      tick(); checks++;
      if ({bus.mac_enable, bus.accum_clear, bus.data_out, bus.coeff_out} !==
          {2'b10, (k == 0) ? 32'd5 : 32'd0, 16'(k + 1)}) begin
        errors++; $display("FAIL run_tap%0d en=%b d=%0d c=%0d want d=%0d c=%0d", k, bus.mac_enable,
                           bus.data_out, bus.coeff_out, (k == 0) ? 5 : 0, k + 1);
      end
    end
    for (int j = 0; j < 2; j++) begin
      tick(); checks++;
      if ({bus.mac_enable, bus.data_out, bus.coeff_out} !== {1'b1, 48'd0}) begin
        errors++; $display("FAIL drain%0d en=%b d=%0d c=%0d want 1 0 0", j, bus.mac_enable, bus.data_out, bus.coeff_out);
      end
    end
    tick(); checks++;
    if ({bus.mac_enable, bus.frame_done, bus.busy} !== 3'b001) begin
      errors++; $display("FAIL done_cycle en=%b fd=%b busy=%b want 0 0 1", bus.mac_enable, bus.frame_done, bus.busy);
    end
    tick(); checks++;
    if ({bus.frame_done, bus.sample_ready, bus.busy} !== 3'b110) begin
      errors++; $display("FAIL frame_done fd=%b rdy=%b busy=%b want 1 1 0", bus.frame_done, bus.sample_ready, bus.busy);
    end
    tick(); checks++;
    if (bus.frame_done !== 1'b0) begin
      errors++; $display("FAIL frame_done_pulse fd=%b want 0", bus.frame_done);
    end
  endtask

  task automatic test_back_to_back();
    int acc_t[3];
    int n = 0, t = 0;
    do_reset(); load_coeffs();
    bus.sample_in = 1; bus.sample_valid = 1'b1;
    while (n < 3 && t < 100) begin
      if (bus.sample_ready) begin
        acc_t[n] = t; n++;
        tick(); t++;
        bus.sample_in = DW'(n + 1);
        if (n == 3) bus.sample_valid = 1'b0;
      end else begin
        tick(); t++;
      end
    end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL b2b_timeout accepted=%0d want 3", n);
    end
    // Ready returns NUM_TAPS+4 cycles after the edge that took the previous sample.
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (acc_t[i] - acc_t[i-1] - 1 !== NT + 4) begin
        errors++; $display("FAIL b2b_gap%0d got %0d want %0d", i, acc_t[i] - acc_t[i-1] - 1, NT + 4);
      end
    end
    for (int k = 0; k < NT; k++) begin
      tick(); checks++;
      if (bus.data_out !== ((k < 3) ? DW'(3 - k) : DW'(0))) begin
        errors++; $display("FAIL b2b_tap%0d d=%0d want %0d", k, bus.data_out, (k < 3) ? 3 - k : 0);
      end
    end
  endtask

  task automatic test_coeff_err();
    int w;
    do_reset(); load_coeffs(); send(7);
    tick(); tick();
    bus.coeff_wr_en = 1'b1; bus.coeff_wr_addr = 4'd2; bus.coeff_wr_data = 16'd99;
    tick(); bus.coeff_wr_en = 1'b0; checks++;
    if (bus.coeff_wr_err !== 1'b1) begin
      errors++; $display("FAIL err_busy got %b want 1", bus.coeff_wr_err);
    end
    tick(); checks++;
    if (bus.coeff_wr_err !== 1'b0) begin
      errors++; $display("FAIL err_pulse got %b want 0", bus.coeff_wr_err);
    end
    w = 0;
    while (!bus.sample_ready && w < 30) begin tick(); w++; end
    checks++;
    if (bus.sample_ready !== 1'b1) begin
      errors++; $display("FAIL err_wait_idle rdy=%b want 1", bus.sample_ready);
    end
    bus.coeff_wr_en = 1'b1; bus.coeff_wr_addr = 4'd9; bus.coeff_wr_data = 16'd55;
    tick(); bus.coeff_wr_en = 1'b0; checks++;
    if ({bus.coeff_wr_err, bus.busy} !== 2'b10) begin
      errors++; $display("FAIL err_range err=%b busy=%b want 1 0", bus.coeff_wr_err, bus.busy);
    end
    // A write in the accepting cycle is used by that same frame.
    bus.coeff_wr_en = 1'b1; bus.coeff_wr_addr = 4'd0; bus.coeff_wr_data = 16'd42;
    send(10); bus.coeff_wr_en = 1'b0; checks++;
    if ({bus.coeff_wr_err, bus.accum_clear} !== 2'b01) begin
      errors++; $display("FAIL wr_with_sample err=%b clr=%b want 0 1", bus.coeff_wr_err, bus.accum_clear);
    end
    for (int k = 0; k < NT; k++) begin
      tick(); checks++;
      if ({bus.data_out, bus.coeff_out} !== {(k == 0) ? 32'd10 : (k == 1) ? 32'd7 : 32'd0,
                                             (k == 0) ? 16'd42 : 16'(k + 1)}) begin
        errors++; $display("FAIL bank_tap%0d d=%0d c=%0d want d=%0d c=%0d", k, bus.data_out, bus.coeff_out,
                           (k == 0) ? 10 : (k == 1) ? 7 : 0, (k == 0) ? 42 : k + 1);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int fd = 0;
    do_reset(); load_coeffs(); send(9);
    repeat (4) tick();
    checks++;
    if ({bus.mac_enable, bus.coeff_out} !== {1'b1, 16'd4}) begin
      errors++; $display("FAIL mid_k3 en=%b c=%0d want 1 4", bus.mac_enable, bus.coeff_out);
    end
    rst_n = 1'b0; #1; checks++;
    if ({bus.mac_enable, bus.accum_clear, bus.busy, bus.sample_ready, bus.data_out, bus.coeff_out}
        !== {4'b0001, 48'd0}) begin
      errors++; $display("FAIL mid_async en=%b busy=%b rdy=%b d=%0d c=%0d", bus.mac_enable, bus.busy,
                         bus.sample_ready, bus.data_out, bus.coeff_out);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin tick(); if (bus.frame_done) fd++; end
    checks++;
    if (fd !== 0) begin
      errors++; $display("FAIL mid_no_done pulses=%0d want 0", fd);
    end
    load_coeffs(); send(4);
    for (int k = 0; k < NT; k++) begin
      tick(); checks++;
      if ({bus.data_out, bus.coeff_out} !== {(k == 0) ? 32'd4 : 32'd0, 16'(k + 1)}) begin
        errors++; $display("FAIL mid_next_tap%0d d=%0d c=%0d want d=%0d c=%0d", k, bus.data_out,
                           bus.coeff_out, (k == 0) ? 4 : 0, k + 1);
      end
    end
  endtask

  task automatic test_mac_model();
    int w;
    do_reset(); load_coeffs();
    for (int j = 0; j < NT; j++) begin
      send((j == 0) ? 32'd1 : 32'd0);
      w = 0;
      while (!bus.frame_done && w < 30) begin tick(); w++; end
      checks++;
      if (bus.frame_done !== 1'b1 || m_acc !== 64'(j + 1)) begin
        errors++; $display("FAIL mac_frame%0d fd=%b acc=%0d want 1 %0d", j, bus.frame_done, m_acc, j + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_coeff_err();
    test_reset_midframe();
    test_mac_model();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
